// File: rtl/ltc2387_conv_sequencer.sv
// LTC2387-18 conversion sequencer: CNV timing, ADC clock-burst gating, word capture
// and a valid/ready output register with sticky overrun/timeout flags.
module ltc2387_conv_sequencer #(
  parameter int CNV_HIGH_CYCLES = 2,
  parameter int CONV_CYCLES     = 20,
  parameter int BURST_CYCLES    = 9,
  parameter int TIMEOUT_CYCLES  = 8,
  parameter int PERIOD_W        = 16,
  parameter int COUNT_W         = 16
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  num_samples,
  input  logic                err_clear,
  output logic                cnv,
  output logic                clk_en,
  input  logic [17:0]         adc_data_in,
  input  logic                adc_data_valid_in,
  output logic [17:0]         sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic                timeout
);

  localparam int MIN_PERIOD = CONV_CYCLES + BURST_CYCLES + TIMEOUT_CYCLES;

  localparam logic [PERIOD_W-1:0] T_ONE        = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] T_CNV_HIGH   = PERIOD_W'(CNV_HIGH_CYCLES);
  localparam logic [PERIOD_W-1:0] T_CONV_LAST  = PERIOD_W'(CONV_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] T_BURST_LAST = PERIOD_W'(CONV_CYCLES + BURST_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] T_WIN_LAST   = PERIOD_W'(MIN_PERIOD - 1);
  localparam logic [PERIOD_W-1:0] T_MIN_PERIOD = PERIOD_W'(MIN_PERIOD);
  localparam logic [COUNT_W-1:0]  N_ONE        = COUNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_BURST,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] t, t_nxt;
  logic [PERIOD_W-1:0] p_eff;
  logic [COUNT_W-1:0]  n_target, n_count;
  logic                stop_flag, got_word, done_nxt;
  logic                end_req, samples_met, last_window;
  logic                in_window, win_end, accept, load, drop, to_set, run_start;

  assign end_req     = stop_flag | stop;
  assign samples_met = (n_target != '0) && (n_count == n_target);
  assign last_window = (n_target != '0) && ((n_count + N_ONE) == n_target);

  // The timeline t runs 0..P-1 per conversion; BURST+WAIT is exactly the acceptance window.
  assign in_window = (state == S_BURST) || (state == S_WAIT);
  assign win_end   = (state == S_WAIT) && (t == T_WIN_LAST);
  assign accept    = in_window && adc_data_valid_in && !got_word;
  assign load      = accept && (!sample_valid || sample_ready);
  assign drop      = accept && sample_valid && !sample_ready;
  assign to_set    = win_end && !got_word && !accept;
  assign run_start = (state == S_IDLE) && (state_nxt == S_CONV);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt = state;
    t_nxt     = t + T_ONE;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        t_nxt = '0;
        if (start && !stop) state_nxt = S_CONV;
      end
      S_CONV:  if (t == T_CONV_LAST)  state_nxt = S_BURST;
      S_BURST: if (t == T_BURST_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (t == T_WIN_LAST) begin
          if (end_req || (p_eff == T_MIN_PERIOD && last_window)) begin
            state_nxt = S_IDLE;
            t_nxt     = '0;
            done_nxt  = 1'b1;
          end else if (p_eff == T_MIN_PERIOD) begin
            state_nxt = S_CONV;
            t_nxt     = '0;
          end else begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (t == p_eff - T_ONE) begin
          t_nxt = '0;
          if (end_req || samples_met) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_CONV;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears
  // every register so a reset mid-burst drops cnv/clk_en immediately.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      t            <= '0;
      p_eff        <= '0;
      n_target     <= '0;
      n_count      <= '0;
      stop_flag    <= 1'b0;
      got_word     <= 1'b0;
      cnv          <= 1'b0;
      clk_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      cnv       <= (state_nxt == S_CONV) && (t_nxt < T_CNV_HIGH);
      clk_en    <= (state_nxt == S_BURST);
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
      stop_flag <= (state_nxt == S_IDLE) ? 1'b0 : end_req;

      if (run_start) begin
        p_eff    <= (period < T_MIN_PERIOD) ? T_MIN_PERIOD : period;
        n_target <= num_samples;
        n_count  <= '0;
      end else if (win_end) begin
        n_count <= n_count + N_ONE;
      end

      if (state_nxt == S_CONV) got_word <= 1'b0;
      else if (accept)         got_word <= 1'b1;

      if (load) begin
        sample_data  <= adc_data_in;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // A set event in the same cycle as err_clear keeps the flag set.
      if (drop)           overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;

      if (to_set)         timeout <= 1'b1;
      else if (err_clear) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ltc2387_conv_sequencer.sv
// Scoreboard bench for ltc2387_conv_sequencer: a per-run timeline model predicts CNV/burst
// timing, accepted words and flags; a forked monitor pops expected words on each handshake.
module tb_ltc2387_conv_sequencer;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] num_samples = '0;
  logic        err_clear = 1'b0;
  logic        cnv, clk_en;
  logic [17:0] adc_data_in = '0;
  logic        adc_data_valid_in = 1'b0;
  logic [17:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy, done, overrun, timeout;

  ltc2387_conv_sequencer dut (
    .sys_clk           (sys_clk),
    .reset             (reset),
    .start             (start),
    .stop              (stop),
    .period            (period),
    .num_samples       (num_samples),
    .err_clear         (err_clear),
    .cnv               (cnv),
    .clk_en            (clk_en),
    .adc_data_in       (adc_data_in),
    .adc_data_valid_in (adc_data_valid_in),
    .sample_data       (sample_data),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .busy              (busy),
    .done              (done),
    .overrun           (overrun),
    .timeout           (timeout)
  );

  localparam int MIN_P = 37;

  initial forever #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Scoreboard and observation records.
  logic [17:0] exp_q[$];
  int          cnv_q[$], clken_q[$], done_q[$];
  int          cnv_hi = 0, clken_hi = 0;

  // Model state that persists across cycles of a run.
  bit m_full = 0, m_to = 0, m_over = 0, got = 0;
  int so[8][3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic cnv_d = 1'b0;
    logic clken_d = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (reset) begin
        cnv_d   = 1'b0;
        clken_d = 1'b0;
      end else begin
        if (cnv && !cnv_d)       cnv_q.push_back(cyc);
        if (clk_en && !clken_d)  clken_q.push_back(cyc);
        if (cnv)    cnv_hi++;
        if (clk_en) clken_hi++;
        cnv_d   = cnv;
        clken_d = clk_en;
        if (done) begin
          done_q.push_back(cyc);
          check("busy_at_done", busy, 0);
        end
        if (sample_valid && sample_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got 0x%0h, expected no word", sample_data);
          end else begin
            check("sample_data", sample_data, exp_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic clear_obs();
    cnv_q.delete();
    clken_q.delete();
    done_q.delete();
    cnv_hi   = 0;
    clken_hi = 0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    @(posedge sys_clk); #1;
    err_clear = 1'b0;
    m_to   = 0;
    m_over = 0;
  endtask

  // One run: n_conv conversions at effective period max(p_in, 37). stop_conv >= 0 pulses
  // stop at t=5 of that conversion; miss_conv gets no in-window strobe; ready_mode 1 stalls
  // the sink over two conversions, ready_mode 2 drains exactly as the second word lands.
  task automatic run_case(input int p_in, input int n_in, input int n_conv, input int stop_conv,
                          input int miss_conv, input int ready_mode, input bit clear_at_to);
    int pe, t0, end_rel;
    pe = (p_in < MIN_P) ? MIN_P : p_in;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 3; k++) so[j][k] = -1;
    for (int j = 0; j < n_conv; j++) begin
      if (ready_mode != 0) begin
        so[j][0] = 30;
      end else if (j == miss_conv) begin
        so[j][0] = $urandom_range(0, 19);
        if (pe > MIN_P) so[j][1] = $urandom_range(MIN_P, pe - 1);
      end else begin
        so[j][0] = $urandom_range(20, 36);
        if ($urandom_range(0, 1) == 1) so[j][1] = $urandom_range(0, 19);
        if (so[j][0] < 36 && $urandom_range(0, 1) == 1) so[j][2] = $urandom_range(so[j][0] + 1, 36);
      end
    end
    end_rel = (n_conv - 1) * pe + ((stop_conv >= 0) ? MIN_P : pe);

    @(posedge sys_clk); #1;
    start       = 1'b1;
    period      = 16'(p_in);
    num_samples = 16'(n_in);
    t0          = cyc + 1;
    @(posedge sys_clk); #1;

    for (int r = 0; r < end_rel + 6; r++) begin
      int j, s;
      bit act, v, acc, ld;
      logic [17:0] d;
      j   = r / pe;
      s   = r % pe;
      act = (r < end_rel) && (j < n_conv);
      v   = 0;
      start     = 1'b0;
      stop      = 1'b0;
      err_clear = 1'b0;
      sample_ready = 1'b1;
      if (act) begin
        v = (s == so[j][0]) || (s == so[j][1]) || (s == so[j][2]);
        if (j == stop_conv && s == 5) stop = 1'b1;
        if (ready_mode == 0 && j == 0 && s == 3) begin
          start  = 1'b1;
          period = 16'd200;
        end
        if (clear_at_to && j == miss_conv && s == 36) err_clear = 1'b1;
        if (ready_mode == 1) sample_ready = (j >= 2);
        if (ready_mode == 2) sample_ready = !((j == 0 && s > 30) || (j == 1 && s < 30));
      end
      d = 18'($urandom);
      adc_data_in       = d;
      adc_data_valid_in = v;

      acc = 0;
      ld  = 0;
      if (act) begin
        if (s == 0) got = 0;
        acc = v && (s >= 20) && (s <= 36) && !got;
        if (acc) got = 1;
        if (acc && (!m_full || sample_ready)) begin
          exp_q.push_back(d);
          ld = 1;
        end
        if (s == 36 && !got)           m_to = 1;
        else if (err_clear)            m_to = 0;
        if (acc && m_full && !sample_ready) m_over = 1;
        else if (err_clear)            m_over = 0;
      end
      if (ld)                        m_full = 1;
      else if (m_full && sample_ready) m_full = 0;

      @(posedge sys_clk); #1;
    end
    adc_data_valid_in = 1'b0;
    sample_ready      = 1'b1;

    check("cnv_count", cnv_q.size(), n_conv);
    for (int j = 0; j < n_conv && j < cnv_q.size(); j++) check("cnv_rise", cnv_q[j], t0 + j * pe);
    check("clk_en_count", clken_q.size(), n_conv);
    for (int j = 0; j < n_conv && j < clken_q.size(); j++)
      check("clk_en_rise", clken_q[j], t0 + j * pe + 20);
    check("clk_en_width", clken_hi, 9 * n_conv);
    check("cnv_width", cnv_hi, 2 * n_conv);
    check("done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("done_cycle", done_q[0], t0 + end_rel);
    check("busy_idle", busy, 0);
    check("timeout_flag", timeout, m_to);
    check("overrun_flag", overrun, m_over);
    check("words_drained", exp_q.size(), 0);
    check("valid_idle", sample_valid, 0);
    clear_obs();
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge sys_clk);
    #3 reset = 1'b0;
    @(posedge sys_clk); #1;
    check("rst_cnv", cnv, 0);
    check("rst_clk_en", clk_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);

    // stop alone in IDLE, then start+stop together: both leave the sequencer idle.
    stop = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b1;
    period = 16'd100;
    num_samples = 16'd1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    check("idle_start_stop_busy", busy, 0);
    check("idle_start_stop_cnv", cnv_q.size(), 0);
    check("idle_start_stop_done", done_q.size(), 0);
    clear_obs();

    run_case(100, 3, 3, -1, -1, 0, 0);
    run_case(10, 2, 2, -1, -1, 0, 0);
    run_case(100, 3, 3, -1, 1, 0, 1);
    pulse_err_clear();
    check("timeout_cleared", timeout, m_to);
    run_case(60, 3, 3, -1, -1, 1, 0);
    pulse_err_clear();
    check("overrun_cleared", overrun, m_over);
    run_case(60, 2, 2, -1, -1, 2, 0);
    run_case(50, 0, 4, 3, -1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      int p, n;
      p = $urandom_range(10, 80);
      n = $urandom_range(1, 3);
      run_case(p, n, n, -1, -1, 0, 0);
    end

    // Reset in the middle of the clock burst.
    @(posedge sys_clk); #1;
    start = 1'b1;
    period = 16'd100;
    num_samples = 16'd0;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (24) @(posedge sys_clk);
    #1;
    check("pre_reset_clk_en", clk_en, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cnv", cnv, 0);
    check("mid_rst_clk_en", clk_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_flags", {overrun, timeout}, 0);
    m_full = 0;
    m_to   = 0;
    m_over = 0;
    exp_q.delete();
    repeat (2) @(posedge sys_clk);
    #3 reset = 1'b0;
    clear_obs();
    repeat (60) @(posedge sys_clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_no_cnv", cnv_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
